// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the instruction memory request, buffers one
// word under downstream stall, and applies prioritized PC redirects.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter logic [31:0] EXCEPTION_VECTOR = 32'h0000_F000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Exception,
    input  logic        Eret,
    input  logic        Jr,
    input  logic        Jump,
    input  logic        Branch_taken,
    input  logic [31:0] Epc_in,
    input  logic [31:0] Jr_target,
    input  logic [31:0] Jump_target,
    input  logic [31:0] Branch_target,
    output logic        Imem_request,
    output logic [31:0] Imem_address,
    input  logic        Imem_ready,
    input  logic [31:0] Imem_data,
    output logic [31:0] PC_out,
    output logic [31:0] PC_plus_4_out,
    output logic [31:0] Instruction_out,
    output logic        Instruction_valid
);

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] buf_data, buf_data_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic [31:0] pc_out_nxt, pc_plus_4_out_nxt, instruction_nxt;
    logic        valid_nxt;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] redirect_pc;
    logic [31:0] pc_plus_4;
    logic [31:0] buf_pc_plus_4;

    // 32-bit adders wrap naturally, so 0xFFFF_FFFC + 4 yields 0.
    assign pc_plus_4     = pc + 32'd4;
    assign buf_pc_plus_4 = buf_pc + 32'd4;

    assign Imem_request = (state == REQ);
    assign Imem_address = pc;

    // Redirect arbitration, highest priority first; targets are word-aligned.
    always_comb begin
        // NOTE: every variable driven here gets a default first so no path
        // through the if-chain can leave it unassigned and infer a latch.
        redirect        = 1'b1;
        redirect_target = Branch_target;
        if (Exception)         redirect_target = EXCEPTION_VECTOR;
        else if (Eret)         redirect_target = Epc_in;
        else if (Jr)           redirect_target = Jr_target;
        else if (Jump)         redirect_target = Jump_target;
        else if (Branch_taken) redirect_target = Branch_target;
        else                   redirect        = 1'b0;
    end

    assign redirect_pc = {redirect_target[31:2], 2'b00};

    always_comb begin
        state_nxt         = state;
        pc_nxt            = pc;
        buf_data_nxt      = buf_data;
        buf_pc_nxt        = buf_pc;
        pc_out_nxt        = PC_out;
        pc_plus_4_out_nxt = PC_plus_4_out;
        instruction_nxt   = Instruction_out;
        valid_nxt         = Instruction_valid;

        if (redirect) begin
            // Redirect wins over stall, flush, and any word returning this cycle.
            pc_nxt       = redirect_pc;
            valid_nxt    = 1'b0;
            buf_data_nxt = '0;
            buf_pc_nxt   = '0;
            state_nxt    = REQ;
        end else if (Flush) begin
            valid_nxt    = 1'b0;
            buf_data_nxt = '0;
            buf_pc_nxt   = '0;
            state_nxt    = REQ;
            // An accepted fetch still advances the PC; only its word is dropped.
            if (state == REQ && Imem_ready && !Stall) begin
                pc_nxt = pc_plus_4;
            end
        end else begin
            case (state)
                REQ: begin
                    if (Imem_ready) begin
                        if (Stall) begin
                            buf_data_nxt = Imem_data;
                            buf_pc_nxt   = pc;
                            state_nxt    = HOLD;
                        end else begin
                            instruction_nxt   = Imem_data;
                            pc_out_nxt        = pc;
                            pc_plus_4_out_nxt = pc_plus_4;
                            valid_nxt         = 1'b1;
                            pc_nxt            = pc_plus_4;
                        end
                    end else if (!Stall) begin
                        valid_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        instruction_nxt   = buf_data;
                        pc_out_nxt        = buf_pc;
                        pc_plus_4_out_nxt = buf_pc_plus_4;
                        valid_nxt         = 1'b1;
                        pc_nxt            = buf_pc_plus_4;
                        state_nxt         = REQ;
                    end
                end
                default: state_nxt = REQ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state             <= REQ;
            pc                <= RESET_PC;
            buf_data          <= '0;
            buf_pc            <= '0;
            PC_out            <= '0;
            PC_plus_4_out     <= '0;
            Instruction_out   <= '0;
            Instruction_valid <= 1'b0;
        end else begin
            state             <= state_nxt;
            pc                <= pc_nxt;
            buf_data          <= buf_data_nxt;
            buf_pc            <= buf_pc_nxt;
            PC_out            <= pc_out_nxt;
            PC_plus_4_out     <= pc_plus_4_out_nxt;
            Instruction_out   <= instruction_nxt;
            Instruction_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a table of per-cycle vectors followed
// by hand-written streaming and stall-then-redirect sequences.
module tb_instruction_fetch;

    localparam logic [31:0] RST = 32'h0000_0200;
    localparam logic [31:0] EXV = 32'h0000_F000;

    localparam logic [31:0] EPC_IN  = 32'h0000_2006;
    localparam logic [31:0] JR_TGT  = 32'h0000_3001;
    localparam logic [31:0] JMP_TGT = 32'h0000_4002;

    localparam logic [8:0] RSTA = 9'h100;
    localparam logic [8:0] STL  = 9'h080;
    localparam logic [8:0] FLS  = 9'h040;
    localparam logic [8:0] EXC  = 9'h020;
    localparam logic [8:0] ERT  = 9'h010;
    localparam logic [8:0] JRQ  = 9'h008;
    localparam logic [8:0] JMP  = 9'h004;
    localparam logic [8:0] BRT  = 9'h002;
    localparam logic [8:0] RDY  = 9'h001;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] pco;
        logic [31:0] p4;
        logic [31:0] ins;
        logic        valid;
    } out_t;

    typedef struct {
        string       name;
        logic [8:0]  ctl;
        logic [31:0] br_tgt;
        logic [31:0] data;
        out_t        exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        Stall, Flush, Exception, Eret, Jr, Jump, Branch_taken;
    logic [31:0] Epc_in, Jr_target, Jump_target, Branch_target;
    logic        Imem_request;
    logic [31:0] Imem_address;
    logic        Imem_ready;
    logic [31:0] Imem_data;
    logic [31:0] PC_out, PC_plus_4_out, Instruction_out;
    logic        Instruction_valid;

    int vectors_applied = 0;
    int miscompares     = 0;

    instruction_fetch #(
        .RESET_PC(RST),
        .EXCEPTION_VECTOR(EXV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .Stall(Stall),
        .Flush(Flush),
        .Exception(Exception),
        .Eret(Eret),
        .Jr(Jr),
        .Jump(Jump),
        .Branch_taken(Branch_taken),
        .Epc_in(Epc_in),
        .Jr_target(Jr_target),
        .Jump_target(Jump_target),
        .Branch_target(Branch_target),
        .Imem_request(Imem_request),
        .Imem_address(Imem_address),
        .Imem_ready(Imem_ready),
        .Imem_data(Imem_data),
        .PC_out(PC_out),
        .PC_plus_4_out(PC_plus_4_out),
        .Instruction_out(Instruction_out),
        .Instruction_valid(Instruction_valid)
    );

    always #5 clock = ~clock;

    function automatic out_t eo(input logic req, input logic [31:0] addr, pco, p4, ins,
                                input logic valid);
        out_t o;
        o.req = req; o.addr = addr; o.pco = pco; o.p4 = p4; o.ins = ins; o.valid = valid;
        return o;
    endfunction

    function automatic vec_t mk(input string name, input logic [8:0] ctl,
                                input logic [31:0] br_tgt, data, input out_t exp);
        vec_t v;
        v.name = name; v.ctl = ctl; v.br_tgt = br_tgt; v.data = data; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input logic [8:0] ctl, input logic [31:0] br_tgt, data);
        reset        = ~|(ctl & RSTA);
        Stall        = |(ctl & STL);
        Flush        = |(ctl & FLS);
        Exception    = |(ctl & EXC);
        Eret         = |(ctl & ERT);
        Jr           = |(ctl & JRQ);
        Jump         = |(ctl & JMP);
        Branch_taken = |(ctl & BRT);
        Imem_ready   = |(ctl & RDY);
        Branch_target = br_tgt;
        Imem_data     = data;
    endtask

    task automatic check(input string name, input out_t e);
        out_t got;
        got.req = Imem_request;   got.addr = Imem_address;
        got.pco = PC_out;         got.p4 = PC_plus_4_out;
        got.ins = Instruction_out; got.valid = Instruction_valid;
        vectors_applied++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s: got req=%b addr=%h pc=%h pc4=%h ins=%h v=%b, want req=%b addr=%h pc=%h pc4=%h ins=%h v=%b",
                     name, got.req, got.addr, got.pco, got.p4, got.ins, got.valid,
                     e.req, e.addr, e.pco, e.p4, e.ins, e.valid);
        end
    endtask

    task automatic step(input string name, input logic [8:0] ctl, input logic [31:0] br_tgt,
                        data, input out_t e);
        drive(ctl, br_tgt, data);
        @(posedge clock);
        #1;
        check(name, e);
    endtask

    vec_t vecs[$];

    initial begin
        Epc_in      = EPC_IN;
        Jr_target   = JR_TGT;
        Jump_target = JMP_TGT;
        drive(RSTA, 32'h0, 32'h0);

        // Streaming after reset
        vecs.push_back(mk("reset_a",   RSTA | RDY, 0, 32'hDEAD, eo(1, RST,      0,       0,       0,     0)));
        vecs.push_back(mk("stream_11", RDY,        0, 32'h11,   eo(1, RST+4,    RST,     RST+4,   32'h11, 1)));
        vecs.push_back(mk("stream_22", RDY,        0, 32'h22,   eo(1, RST+8,    RST+4,   RST+8,   32'h22, 1)));
        vecs.push_back(mk("stream_33", RDY,        0, 32'h33,   eo(1, RST+12,   RST+8,   RST+12,  32'h33, 1)));
        // Wait states at RST+8, then stall with the next word buffered
        vecs.push_back(mk("reset_b",   RSTA | RDY, 0, 32'h55,   eo(1, RST,      0,       0,       0,     0)));
        vecs.push_back(mk("b_11",      RDY,        0, 32'h11,   eo(1, RST+4,    RST,     RST+4,   32'h11, 1)));
        vecs.push_back(mk("b_22",      RDY,        0, 32'h22,   eo(1, RST+8,    RST+4,   RST+8,   32'h22, 1)));
        vecs.push_back(mk("wait_1",    0,          0, 32'h99,   eo(1, RST+8,    RST+4,   RST+8,   32'h22, 0)));
        vecs.push_back(mk("wait_2",    0,          0, 32'h99,   eo(1, RST+8,    RST+4,   RST+8,   32'h22, 0)));
        vecs.push_back(mk("stall_cap", STL | RDY,  0, 32'h33,   eo(0, RST+8,    RST+4,   RST+8,   32'h22, 0)));
        vecs.push_back(mk("stall_2",   STL | RDY,  0, 32'h44,   eo(0, RST+8,    RST+4,   RST+8,   32'h22, 0)));
        vecs.push_back(mk("stall_3",   STL,        0, 32'h0,    eo(0, RST+8,    RST+4,   RST+8,   32'h22, 0)));
        vecs.push_back(mk("release",   0,          0, 32'h0,    eo(1, RST+12,   RST+8,   RST+12,  32'h33, 1)));
        vecs.push_back(mk("after_rel", RDY,        0, 32'h44,   eo(1, RST+16,   RST+12,  RST+16,  32'h44, 1)));
        // Redirect priority and alignment
        vecs.push_back(mk("exc_jmp_stl", STL|EXC|JMP|RDY, 0, 32'h66, eo(1, EXV, RST+12, RST+16, 32'h44, 0)));
        vecs.push_back(mk("eret_wins", ERT|JRQ|JMP|BRT|RDY, 32'h5000, 32'h77, eo(1, 32'h2004, RST+12, RST+16, 32'h44, 0)));
        vecs.push_back(mk("jr_wins",   JRQ|JMP|BRT, 32'h5000, 32'h0, eo(1, 32'h3000, RST+12, RST+16, 32'h44, 0)));
        vecs.push_back(mk("jump_wins", JMP|BRT,     32'h5000, 32'h0, eo(1, 32'h4000, RST+12, RST+16, 32'h44, 0)));
        vecs.push_back(mk("br_align",  BRT,         32'h0103, 32'h0, eo(1, 32'h0100, RST+12, RST+16, 32'h44, 0)));
        vecs.push_back(mk("fetch_100", RDY,         0, 32'h88,   eo(1, 32'h104, 32'h100, 32'h104, 32'h88, 1)));
        // Flush during accept advances PC; flush in HOLD discards the buffer
        vecs.push_back(mk("flush_adv", FLS | RDY,   0, 32'h99,   eo(1, 32'h108, 32'h100, 32'h104, 32'h88, 0)));
        vecs.push_back(mk("hold_aa",   STL | RDY,   0, 32'hAA,   eo(0, 32'h108, 32'h100, 32'h104, 32'h88, 0)));
        vecs.push_back(mk("flush_hold", FLS | STL,  0, 32'h0,    eo(1, 32'h108, 32'h100, 32'h104, 32'h88, 0)));
        vecs.push_back(mk("refetch",   RDY,         0, 32'hBB,   eo(1, 32'h10C, 32'h108, 32'h10C, 32'hBB, 1)));
        // Wrap at top of address space
        vecs.push_back(mk("br_top",    BRT, 32'hFFFF_FFFF, 32'h0, eo(1, 32'hFFFF_FFFC, 32'h108, 32'h10C, 32'hBB, 0)));
        vecs.push_back(mk("wrap",      RDY,         0, 32'hCC,   eo(1, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'hCC, 1)));
        // Reset while in HOLD
        vecs.push_back(mk("hold_dd",   STL | RDY,   0, 32'hDD,   eo(0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'hCC, 1)));
        vecs.push_back(mk("rst_hold",  RSTA|STL|RDY, 0, 32'hEE,  eo(1, RST, 0, 0, 0, 0)));
        vecs.push_back(mk("post_rst",  0,           0, 32'h0,    eo(1, RST, 0, 0, 0, 0)));

        foreach (vecs[i]) step(vecs[i].name, vecs[i].ctl, vecs[i].br_tgt, vecs[i].data, vecs[i].exp);

        // One instruction per cycle with ready held high
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = RST + 32'(4 * i);
            step($sformatf("sustain_%0d", i), RDY, 0, 32'h1000 + 32'(i),
                 eo(1, a + 4, a, a + 4, 32'h1000 + 32'(i), 1));
        end

        // Stall into HOLD, then a stalled Eret must drop the buffered word
        step("seq_hold",  STL | RDY,       0, 32'hBAD,  eo(0, RST+32, RST+28, RST+32, 32'h1007, 1));
        step("seq_eret",  STL | ERT | RDY, 0, 32'hBAD2, eo(1, 32'h2004, RST+28, RST+32, 32'h1007, 0));
        step("seq_fetch", RDY,             0, 32'hC0DE, eo(1, 32'h2008, 32'h2004, 32'h2008, 32'hC0DE, 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
